// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// =============================================================================
// alu_issue_ctrl : command FIFO, registered issue stage and carry/zero flag
//                  register for the 4-bit ALU. Optional macro:
//                  ALU_ISSUE_ILLEGAL_DROP_EN (drop opcodes 14/15 at the input).
// Revision       : 1.0
// =============================================================================
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [3:0]               i_cmd_a,
  input  logic [3:0]               i_cmd_b,
  input  logic [3:0]               i_cmd_op,
  input  logic                     i_issue_en,
  input  logic                     i_flag_clr,
  output logic                     o_valid_in,
  output logic [3:0]               o_a,
  output logic [3:0]               o_b,
  output logic                     o_cin,
  output logic [3:0]               o_ctl,
  input  logic                     i_alu_valid_out,
  input  logic                     i_alu_carry,
  input  logic                     i_alu_zero,
  output logic                     o_flag_carry,
  output logic                     o_flag_zero,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_err_illegal
);

  localparam int           AW        = $clog2(DEPTH);
  localparam logic [AW:0]  c_FULL    = (AW+1)'(DEPTH);
  localparam logic [3:0]   c_OP_ADDC = 4'd4;
  localparam logic [3:0]   c_OP_SUBB = 4'd6;

  logic [11:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          r_valid_in;
  logic [3:0]    r_a;
  logic [3:0]    r_b;
  logic          r_cin;
  logic [3:0]    r_ctl;
  logic          r_flag_carry;
  logic          r_flag_zero;

  logic          w_push;
  logic          w_push_fifo;
  logic          w_pop;
  logic          w_illegal;
  logic          w_empty;
  logic [11:0]   w_head;
  logic          w_head_carry;
  logic          w_stall;

  // Readiness depends on occupancy only, so a same-cycle pop never frees space.
  assign o_cmd_ready  = (r_count != c_FULL);
  assign w_empty      = (r_count == '0);
  assign w_push       = i_cmd_valid && o_cmd_ready;
  assign w_push_fifo  = w_push && !w_illegal;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_carry = (w_head[3:0] == c_OP_ADDC) || (w_head[3:0] == c_OP_SUBB);
  // A carry consumer waits one bubble so the prior result can be forwarded.
  assign w_stall      = w_head_carry && r_valid_in;
  assign w_pop        = !w_empty && i_issue_en && !w_stall;

`ifdef ALU_ISSUE_ILLEGAL_DROP_EN
  logic r_err_illegal;

  assign w_illegal = (i_cmd_op[3:1] == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_illegal <= 1'b0;
    end else begin
      r_err_illegal <= w_push && w_illegal;
    end
  end

  assign o_err_illegal = r_err_illegal;
`else
  assign w_illegal     = 1'b0;
  assign o_err_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_push_fifo) begin
      r_mem[r_wr_ptr] <= {i_cmd_a, i_cmd_b, i_cmd_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_fifo) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_fifo, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_in <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_cin      <= 1'b0;
      r_ctl      <= '0;
    end else if (w_pop) begin
      r_valid_in <= 1'b1;
      r_a        <= w_head[11:8];
      r_b        <= w_head[7:4];
      r_ctl      <= w_head[3:0];
      r_cin      <= i_alu_valid_out ? i_alu_carry : r_flag_carry;
    end else begin
      r_valid_in <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_carry <= 1'b0;
      r_flag_zero  <= 1'b0;
    end else if (i_flag_clr) begin
      r_flag_carry <= 1'b0;
      r_flag_zero  <= 1'b0;
    end else if (i_alu_valid_out) begin
      r_flag_carry <= i_alu_carry;
      r_flag_zero  <= i_alu_zero;
    end
  end

  assign o_valid_in   = r_valid_in;
  assign o_a          = r_a;
  assign o_b          = r_b;
  assign o_cin        = r_cin;
  assign o_ctl        = r_ctl;
  assign o_flag_carry = r_flag_carry;
  assign o_flag_zero  = r_flag_zero;
  assign o_fifo_count = r_count;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-issue stage sitting directly upstream of the 4-bit ALU. Buffers incoming ALU commands in a small FIFO, presents them to the ALU one per cycle on registered outputs, and owns the architectural carry/zero flag register fed back from the ALU result. Carry-consuming opcodes (ADD_c, SUB_b) are interlocked so that `cin` always reflects the immediately preceding completed operation.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  upstream command present.
- `cmd_ready`  out  1  FIFO can accept; `!full`.
- `cmd_a`  in  4  operand A.
- `cmd_b`  in  4  operand B.
- `cmd_op`  in  4  opcode: 0 SEL, 1 INC, 2 DEC, 3 ADD, 4 ADD_c, 5 SUB, 6 SUB_b, 7 AND, 8 OR, 9 XOR, 10 SHL, 11 SHR, 12 ROL, 13 ROR, 14/15 illegal.
- `issue_en`  in  1  when low, no pops; FIFO still accepts.
- `flag_clr`  in  1  synchronous clear of both flags.
- `valid_in`  out  1  to ALU: command valid this cycle.
- `a`, `b`  out  4 each  to ALU operands.
- `cin`  out  1  to ALU carry input.
- `ctl`  out  4  to ALU opcode.
- `alu_valid_out`  in  1  from ALU: result valid.
- `alu_carry`  in  1  from ALU carry.
- `alu_zero`  in  1  from ALU zero.
- `flag_carry`  out  1  carry flag register.
- `flag_zero`  out  1  zero flag register.
- `fifo_count`  out  $clog2(DEPTH)+1  entries held.
- `err_illegal`  out  1  one-cycle pulse (only with macro, see Configuration).

## Operation
- Push: `cmd_valid && cmd_ready` writes {a,b,op} at tail. Full: `cmd_ready`=0, command held upstream; a same-cycle pop does not free space for a push that cycle.
- Pop condition: FIFO non-empty, `issue_en`=1, no interlock stall.
- Interlock: head op ∈ {ADD_c, SUB_b} and `valid_in`=1 this cycle → stall one cycle (one-bubble rule). No other op ever stalls.
- Output register, per edge: on pop, `valid_in`←1, `a/b/ctl`←head; `cin`←`alu_valid_out ? alu_carry : flag_carry` (forwarding). Without pop, `valid_in`←0, `a/b/ctl/cin` hold.
- Flags: `alu_valid_out`=1 → `flag_carry`←`alu_carry`, `flag_zero`←`alu_zero`; else hold. `flag_clr` wins over a simultaneous update.
- Illegal opcodes (no macro) are queued and issued like any other; the ALU returns no `alu_valid_out`, so flags hold.
- `fifo_count` = push − pop, range 0..DEPTH; pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, sync-to-clk deassert by system): `valid_in`,`a`,`b`,`cin`,`ctl`,`flag_carry`,`flag_zero`,`err_illegal`=0; `fifo_count`=0; `cmd_ready`=1; FIFO contents discarded. Reset mid-stream drops all queued and in-flight commands.
- Latency: command accepted at edge E0 into empty FIFO → `valid_in`=1 after E1.
- Throughput: one command/cycle for non-carry ops; carry op following any issue incurs exactly one idle cycle.
- ALU latency assumed 1: issue visible cycle N → `alu_valid_out` in N+1 → flags updated after edge ending N+1; forwarding covers the carry op presented in N+2.
- `issue_en` low→high: pop may occur on the first edge with it high.

## Configuration
- `ALU_ISSUE_ILLEGAL_DROP_EN` defined: opcodes 14/15 are accepted (`cmd_ready` honoured) but not written to FIFO; `err_illegal` pulses high the cycle after acceptance; `fifo_count` unchanged.
- Undefined: illegal opcodes queued and forwarded; `err_illegal` tied 0.

## Test plan
- Reset then push {a=3,b=4,op=ADD} → `valid_in`=1, a=3,b=4,ctl=3 two edges after push; model ALU returns carry=0 → `flag_carry`=0.
- Back-to-back ADD a=15,b=1 then ADD_c a=0,b=0 → one bubble between issues; ADD_c presented with `cin`=1 (forwarded).
- Push 5 commands with `issue_en`=0, DEPTH=4 → fourth fills FIFO, `cmd_ready`=0, `fifo_count`=4; fifth stalls until `issue_en`=1 and one pop.
- `flag_clr` asserted same cycle as `alu_valid_out`=1,`alu_carry`=1 → `flag_carry`=0 next cycle.
- op=14 pushed: with macro, `err_illegal` pulse, `fifo_count` stays 0, no `valid_in`; without, `valid_in`=1, ctl=14, flags unchanged.
- Assert `reset`=0 with 3 entries queued and `valid_in`=1 → all outputs 0, `fifo_count`=0 immediately (asynchronous).
